// File: rtl/ad7606_emu.sv
// AD7606 parallel-mode chip-side emulator: answers CONVST/CS/RD from the controller
// with BUSY, FRSTDATA and DB, using samples taken from an 8-entry staging file.
module ad7606_emu #(
  parameter int          P_CONV_CYCLES = 200,
  parameter logic [15:0] P_RESET_DATA  = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_smp_valid,
  input  logic [2:0]  i_smp_chnl,
  input  logic [15:0] i_smp_data,
  output logic [15:0] o_conv_cnt,
  output logic        o_ovr,
  input  logic        i_ad_psb_sel,
  input  logic        i_ad_stby,
  input  logic        i_ad_range,
  input  logic [2:0]  i_ad_osc,
  input  logic        i_ad_reset,
  input  logic        i_ad_convstA,
  input  logic        i_ad_convstB,
  input  logic        i_ad_cs,
  input  logic        i_ad_rd,
  output logic        o_ad_busy,
  output logic        o_ad_firstdata,
  output logic [15:0] o_ad_data
);

  localparam int CNT_W = $clog2(P_CONV_CYCLES * 64 + 1);
  localparam logic [CNT_W-1:0] CONV_BASE = CNT_W'(P_CONV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             convst_prev_r;
  logic             rd_prev_r;
  logic             convst_and_s;
  logic             start_evt_s;
  logic             start_ok_s;
  logic             start_ign_s;
  logic             conv_done_s;
  logic             read_evt_s;
  logic [CNT_W-1:0] conv_len_s;
  logic [CNT_W-1:0] busy_cnt_r;
  logic [2:0]       rd_idx_r;
  logic [15:0]      stage_r [8];
  logic [15:0]      conv_r  [8];

  // +-10 V range halves the code with sign extension (arithmetic shift)
  function automatic logic [15:0] range_scale(input logic [15:0] val, input logic rng);
    logic [15:0] res;
    if (rng) begin
      res = {val[15], val[15:1]};
    end else begin
      res = val;
    end
    return res;
  endfunction

  assign convst_and_s = i_ad_convstA & i_ad_convstB;
  assign start_evt_s  = convst_and_s & ~convst_prev_r;
  assign read_evt_s   = ~i_ad_cs & ~i_ad_rd & rd_prev_r & ~i_ad_psb_sel;
  assign start_ign_s  = start_evt_s & ~i_ad_reset & ((state_r == ST_CONV) | i_ad_stby);

  // BUSY length: base cycles scaled by the oversampling code, codes 0 and 7 unscaled
  always_comb begin
    case (i_ad_osc)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6: conv_len_s = CONV_BASE << i_ad_osc;
      default:                            conv_len_s = CONV_BASE;
    endcase
  end

  // FSM next-state and conversion control strobes
  always_comb begin
    state_nxt_s = state_r;
    start_ok_s  = 1'b0;
    conv_done_s = 1'b0;
    if (i_ad_reset) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_evt_s && !i_ad_stby && !i_ad_psb_sel) begin
            start_ok_s  = 1'b1;
            state_nxt_s = ST_CONV;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CONV: begin
          if (busy_cnt_r == CNT_ZERO) begin
            conv_done_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_CONV;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Previous-value registers; convst idles high so its history resets high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      convst_prev_r <= 1'b1;
      rd_prev_r     <= 1'b0;
    end else begin
      convst_prev_r <= convst_and_s;
      rd_prev_r     <= i_ad_rd;
    end
  end

  // Staging file survives chip reset; only the system reset clears it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) begin
        stage_r[i] <= 16'h0000;
      end
    end else if (i_smp_valid) begin
      stage_r[i_smp_chnl] <= i_smp_data;
    end
  end

  // Conversion timing, result snapshot and completed-conversion counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ad_busy  <= 1'b0;
      o_ovr      <= 1'b0;
      o_conv_cnt <= 16'h0000;
      busy_cnt_r <= CNT_ZERO;
      for (int i = 0; i < 8; i++) begin
        conv_r[i] <= P_RESET_DATA;
      end
    end else if (i_ad_reset) begin
      o_ad_busy  <= 1'b0;
      o_ovr      <= 1'b0;
      busy_cnt_r <= CNT_ZERO;
      for (int i = 0; i < 8; i++) begin
        conv_r[i] <= P_RESET_DATA;
      end
    end else begin
      o_ovr <= start_ign_s;
      if (start_ok_s) begin
        o_ad_busy  <= 1'b1;
        busy_cnt_r <= conv_len_s - CNT_ONE;
      end else if (conv_done_s) begin
        o_ad_busy  <= 1'b0;
        o_conv_cnt <= o_conv_cnt + 16'd1;
        for (int i = 0; i < 8; i++) begin
          conv_r[i] <= range_scale(stage_r[i], i_ad_range);
        end
      end else if (state_r == ST_CONV) begin
        busy_cnt_r <= busy_cnt_r - CNT_ONE;
      end
    end
  end

  // Readout: a new conversion rewinds the channel index to channel 1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ad_data      <= 16'h0000;
      o_ad_firstdata <= 1'b0;
      rd_idx_r       <= 3'd0;
    end else if (i_ad_reset) begin
      o_ad_data      <= 16'h0000;
      o_ad_firstdata <= 1'b0;
      rd_idx_r       <= 3'd0;
    end else begin
      if (i_ad_psb_sel) begin
        o_ad_data      <= 16'h0000;
        o_ad_firstdata <= 1'b0;
      end else if (read_evt_s) begin
        o_ad_data      <= conv_r[rd_idx_r];
        o_ad_firstdata <= (rd_idx_r == 3'd0);
      end
      if (start_ok_s) begin
        rd_idx_r <= 3'd0;
      end else if (read_evt_s) begin
        rd_idx_r <= rd_idx_r + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ad7606_emu.sv
// Scoreboard bench for ad7606_emu: stimulus pushes expected reads and BUSY lengths,
// a monitor pops and compares them as the DUT presents them.
module tb_ad7606_emu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        smp_valid;
  logic [2:0]  smp_chnl;
  logic [15:0] smp_data;
  logic [15:0] conv_cnt;
  logic        ovr;
  logic        psb_sel, stby, range_sel, ad_reset, convst_a, convst_b, cs, rd;
  logic [2:0]  osc;
  logic        busy, firstdata;
  logic [15:0] db;

  always #10 clk = ~clk;

  ad7606_emu #(.P_CONV_CYCLES(200), .P_RESET_DATA(16'h0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_smp_valid(smp_valid), .i_smp_chnl(smp_chnl), .i_smp_data(smp_data),
    .o_conv_cnt(conv_cnt), .o_ovr(ovr),
    .i_ad_psb_sel(psb_sel), .i_ad_stby(stby), .i_ad_range(range_sel), .i_ad_osc(osc),
    .i_ad_reset(ad_reset), .i_ad_convstA(convst_a), .i_ad_convstB(convst_b),
    .i_ad_cs(cs), .i_ad_rd(rd),
    .o_ad_busy(busy), .o_ad_firstdata(firstdata), .o_ad_data(db)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ovr_seen = 0;
  logic [16:0] exp_rd_q[$];
  int          exp_busy_q[$];
  logic [15:0] stg [8];
  logic [15:0] conv_m [8];
  int          idx_m;
  logic [15:0] cnt_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] scale(input logic [15:0] v, input logic rng);
    logic signed [15:0] s;
    s = v;
    return rng ? 16'(s >>> 1) : v;
  endfunction

  // Monitor: detects read events and BUSY pulses from the bus, pops expectations
  initial begin : monitor
    logic        prev_rd;
    logic        evt;
    logic        busy_prev;
    int          blen;
    logic [16:0] e;
    prev_rd   = 1'b1;
    busy_prev = 1'b0;
    blen      = 0;
    forever begin
      @(posedge clk);
      evt     = rst_n && !cs && !rd && prev_rd && !psb_sel;
      prev_rd = rd;
      #1;
      if (evt) begin
        if (exp_rd_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL read_unexpected: got %h, expected no read", db);
        end else begin
          e = exp_rd_q.pop_front();
          chk("read_data", {16'h0000, db}, {16'h0000, e[15:0]});
          chk("read_first", {31'd0, firstdata}, {31'd0, e[16]});
        end
      end
      if (ovr === 1'b1) ovr_seen++;
      if (busy === 1'b1) begin
        blen++;
      end else begin
        if (busy_prev) begin
          if (exp_busy_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL busy_unexpected: got length %0d, expected none", blen);
          end else begin
            chk("busy_len", blen, exp_busy_q.pop_front());
          end
        end
        blen = 0;
      end
      busy_prev = (busy === 1'b1);
    end
  end

  task automatic write_stg(input int ch, input logic [15:0] val);
    @(negedge clk);
    smp_valid = 1'b1; smp_chnl = 3'(ch); smp_data = val;
    stg[ch] = val;
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    convst_a = 1'b0; convst_b = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    convst_a = 1'b1; convst_b = 1'b1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy === 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      n_tests++; n_fail++;
      $display("FAIL busy_timeout: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic finish_conv_model();
    cnt_m = cnt_m + 16'd1;
    for (int i = 0; i < 8; i++) conv_m[i] = scale(stg[i], range_sel);
    idx_m = 0;
    chk("conv_cnt", {16'h0000, conv_cnt}, {16'h0000, cnt_m});
  endtask

  task automatic conv(input int n);
    exp_busy_q.push_back(n);
    start_pulse();
    @(posedge clk); #1;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    wait_idle();
    finish_conv_model();
  endtask

  task automatic read_one();
    exp_rd_q.push_back({(idx_m == 0), conv_m[idx_m]});
    idx_m = (idx_m + 1) % 8;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    @(negedge clk);
    rd = 1'b1;
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) read_one();
    @(negedge clk);
    cs = 1'b1;
  endtask

  initial begin : stimulus
    int ovr_b;
    rst_n = 1'b0; smp_valid = 1'b0; smp_chnl = 3'd0; smp_data = 16'h0000;
    psb_sel = 1'b0; stby = 1'b0; range_sel = 1'b0; osc = 3'd0; ad_reset = 1'b0;
    convst_a = 1'b1; convst_b = 1'b1; cs = 1'b1; rd = 1'b1;
    for (int i = 0; i < 8; i++) begin stg[i] = 16'h0000; conv_m[i] = 16'h0000; end
    idx_m = 0; cnt_m = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_first", {31'd0, firstdata}, 32'd0);
    chk("rst_data", {16'h0000, db}, 32'd0);
    chk("rst_ovr", {31'd0, ovr}, 32'd0);
    chk("rst_cnt", {16'h0000, conv_cnt}, 32'd0);

    // Basic conversion and nine reads (ninth wraps to channel 1)
    for (int k = 0; k < 8; k++) write_stg(k, 16'(16'h0101 * (k + 1)));
    conv(200);
    chk("no_ovr", ovr_seen, 0);
    read_n(9);

    // +-10 V scaling with oversampling 2, then CS-high read is ignored
    range_sel = 1'b1; osc = 3'd2;
    write_stg(0, 16'h8000);
    write_stg(1, 16'h7FFF);
    conv(800);
    read_n(2);
    @(negedge clk); rd = 1'b0;
    @(negedge clk); rd = 1'b1;
    @(negedge clk);
    chk("cs_hold_data", {16'h0000, db}, {16'h0000, conv_m[1]});
    chk("cs_hold_first", {31'd0, firstdata}, 32'd0);

    // Oversampling code 7 behaves as code 0
    range_sel = 1'b0; osc = 3'd7;
    conv(200);
    read_n(3);

    // Second CONVST rise 50 cycles into BUSY is ignored with an overrun pulse
    osc = 3'd0;
    ovr_b = ovr_seen;
    exp_busy_q.push_back(200);
    start_pulse();
    @(posedge clk); #1;
    chk("ovr_busy_rise", {31'd0, busy}, 32'd1);
    repeat (48) @(negedge clk);
    convst_a = 1'b0; convst_b = 1'b0;
    @(negedge clk);
    convst_a = 1'b1; convst_b = 1'b1;
    wait_idle();
    finish_conv_model();
    chk("ovr_in_conv", ovr_seen - ovr_b, 1);

    // Standby: start ignored, overrun pulses, counter unchanged
    stby = 1'b1;
    ovr_b = ovr_seen;
    start_pulse();
    @(posedge clk); #1;
    chk("stby_no_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("ovr_stby", ovr_seen - ovr_b, 1);
    chk("stby_cnt", {16'h0000, conv_cnt}, {16'h0000, cnt_m});
    stby = 1'b0;

    // Chip reset at BUSY cycle 100 aborts conversion, results go to reset data
    exp_busy_q.push_back(100);
    start_pulse();
    @(posedge clk); #1;
    chk("abort_busy_rise", {31'd0, busy}, 32'd1);
    repeat (99) @(posedge clk);
    @(negedge clk); ad_reset = 1'b1;
    @(negedge clk); ad_reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_data", {16'h0000, db}, 32'd0);
    chk("abort_cnt", {16'h0000, conv_cnt}, {16'h0000, cnt_m});
    for (int i = 0; i < 8; i++) conv_m[i] = 16'h0000;
    idx_m = 0;
    read_n(8);

    // Controller-style loopback: three frames of fresh staging data
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) write_stg(k, 16'((f + 1) * 4096 + k * 256 + 16'h005A + f * 16'h8000));
      conv(200);
      read_n(8);
    end

    repeat (5) @(negedge clk);
    chk("rd_queue_empty", exp_rd_q.size(), 0);
    chk("busy_queue_empty", exp_busy_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ad7606_emu.md
Name: ad7606_emu

Overview:
- Synthesizable emulator of the AD7606 parallel-mode chip side: the responder to the existing AD7606 controller.
- Accepts RESET/CONVST/CS/RD strobes from the controller in the same i_clk domain and answers with BUSY, FRSTDATA and DB[15:0].
- Used for in-fabric loopback of the acquisition chain and for bench bring-up without the ADC.
- Sample values come from a user-loaded 8-entry staging file.

Parameters:
- P_CONV_CYCLES, 200: base BUSY length in i_clk cycles (4 us at 50 MHz), applied when oversampling is 0.
- P_RESET_DATA, 16'h0000: value loaded into all conversion registers by reset or by i_ad_reset.

Ports:
- i_clk  in  1  system clock, 50 MHz.
- i_rst_n  in  1  asynchronous active-low reset.
- i_smp_valid  in  1  staging write strobe.
- i_smp_chnl  in  3  staging channel index, 0..7.
- i_smp_data  in  16  staging value, two's complement.
- o_conv_cnt  out  16  completed conversions, wraps at 65535 -> 0.
- o_ovr  out  1  one-cycle pulse when a CONVST start is ignored.
- i_ad_psb_sel  in  1  0 = parallel; 1 = block inactive (no conversion, DB held 0).
- i_ad_stby  in  1  1 = standby, conversion starts ignored.
- i_ad_range  in  1  0 = ±5 V, 1 = ±10 V.
- i_ad_osc  in  3  oversampling ratio code.
- i_ad_reset  in  1  chip reset, active high.
- i_ad_convstA  in  1  conversion start, channels 1-4.
- i_ad_convstB  in  1  conversion start, channels 5-8.
- i_ad_cs  in  1  chip select, active low.
- i_ad_rd  in  1  read strobe, active low.
- o_ad_busy  out  1  conversion in progress.
- o_ad_firstdata  out  1  DB currently carries channel 1.
- o_ad_data  out  16  parallel data bus.

Behaviour:
- Clocking and reset
  - All inputs are same-domain: no synchronizers. A single previous-value register is kept for convst and rd.
  - Async reset (i_rst_n = 0) values: o_ad_busy 0, o_ad_firstdata 0, o_ad_data 0, o_ovr 0, o_conv_cnt 0, read index 0, staging file 0, conversion regs P_RESET_DATA, FSM IDLE.
  - i_ad_reset = 1, sampled synchronously, has the same effect except that the staging file and o_conv_cnt are kept. It aborts any conversion in progress and forces IDLE.
- Conversion start
  - Start event: rising edge of (i_ad_convstA & i_ad_convstB), i.e. previous AND = 0 and current AND = 1.
  - The start is accepted only in IDLE with i_ad_stby = 0 and i_ad_psb_sel = 0.
  - A start seen in CONV, or while stby = 1, is ignored and pulses o_ovr for one cycle.
- FSM states: IDLE, CONV.
  - IDLE -> CONV on an accepted start. Next cycle: o_ad_busy = 1, busy counter loads N - 1, read index clears to 0.
  - N = P_CONV_CYCLES << osc for osc 1..6. osc 0 or 7 gives N = P_CONV_CYCLES.
  - CONV: counter decrements each cycle. At count 0: o_ad_busy -> 0, state -> IDLE, conversion regs <= staging snapshot, o_conv_cnt + 1. All four actions occur on the same edge.
  - BUSY is therefore high for exactly N cycles.
- Range scaling at snapshot
  - range 0: value stored unchanged.
  - range 1: arithmetic shift right by 1, so 16'h8000 -> 16'hC000 and 16'h7FFF -> 16'h3FFF.
- Staging writes
  - i_smp_valid writes staging[i_smp_chnl] on the next edge.
  - A write on the same edge as the snapshot is not seen by that snapshot; the pre-write value is captured.
- Readout
  - Read event: i_ad_cs = 0 and i_ad_rd = 0 and previous rd = 1.
  - On the edge that detects a read event: o_ad_data <= conv_reg[idx], o_ad_firstdata <= (idx == 0), idx <= idx + 1 mod 8.
  - Latency: data is valid 1 clock after RD falls and stays stable until the next read event. This meets the controller's capture at RD high + 1 cycle.
  - The 9th read returns channel 1 again.
  - Reads in CONV return the previous conversion results.
  - While cs = 1: DB and firstdata hold, idx unchanged.
  - RD low for consecutive cycles counts as one read.

Test Plan:
- Reset release: all outputs 0; o_ad_data 0; busy 0 -> matches reset table.
- Load staging ch0..7 = 16'h0101..16'h0808, range 0, osc 0, drop convst for 3 cycles then raise -> busy high exactly 200 cycles starting the cycle after the rise, o_conv_cnt = 1.
- After the conversion, 8 RD pulses with CS low, period 2 clocks -> DB = 16'h0101..16'h0808, each valid 1 cycle after RD falls, firstdata only with 16'h0101. A 9th pulse returns 16'h0101.
- range 1, staging ch0 = 16'h8000, ch1 = 16'h7FFF -> reads give 16'hC000, 16'h3FFF. osc = 2 -> busy = 800 cycles. osc = 7 -> busy = 200 cycles.
- Second convst rise 50 cycles into busy -> o_ovr single pulse, busy still ends at cycle 200, o_conv_cnt increments once. Same result with stby = 1 while IDLE: start ignored, o_ovr pulses.
- i_ad_reset pulsed at busy cycle 100 -> busy 0 next cycle, reads return P_RESET_DATA, o_conv_cnt unchanged. Controller loopback for 3 frames -> user channels 1..8 match staging.
